// File: rtl/vga_rect_loader.sv
// Command FIFO plus bus-master sequencer that loads rectangle registers into the
// VGA driver during vertical blanking, re-checking blanking before retiring a command.
module vga_rect_loader #(
   parameter int         DEPTH     = 4,
   parameter int         RD_LAT    = 2,
   parameter logic [5:0] IDLE_ADDR = 6'd0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic [1:0]               cmd_slot,
   input  logic [7:0]               cmd_x1,
   input  logic [7:0]               cmd_y1,
   input  logic [7:0]               cmd_x2,
   input  logic [7:0]               cmd_y2,
   input  logic [7:0]               cmd_color,
   output logic [5:0]               pAddr,
   output logic [7:0]               pDout,
   input  logic [7:0]               pDin,
   output logic                     we,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   level,
   output logic [7:0]               retries
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
   localparam logic [CW-1:0] LAT_INIT = CW'(RD_LAT - 1);
   localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);

   localparam logic [5:0] A_EOF_COL = 6'd14;
   localparam logic [5:0] A_X1      = 6'd15;
   localparam logic [5:0] A_Y1      = 6'd16;
   localparam logic [5:0] A_X2      = 6'd17;
   localparam logic [5:0] A_Y2      = 6'd18;
   localparam logic [5:0] A_SLOT    = 6'd19;

   typedef enum logic [3:0] {
      S_IDLE, S_POLL, S_W_SLOT, S_W_X1, S_W_Y1, S_W_X2,
      S_W_Y2, S_W_COL, S_HOLD, S_CHECK, S_POP
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   lat_cnt_q, lat_cnt_d;
   logic [7:0]      retries_q, retries_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PW:0]     count_q, count_d;
   logic [41:0]     mem_q [DEPTH];
   logic [41:0]     mem_d [DEPTH];
   logic [41:0]     head;
   logic            push, pop;
   logic            unused_din;

   assign unused_din = ^pDin[7:1];

   assign cmd_ready = (count_q != FULL_CNT);
   assign push      = cmd_valid && cmd_ready;
   assign head      = mem_q[rd_ptr_q];
   assign busy      = (state_q != S_IDLE);
   assign level     = count_q;
   assign retries   = retries_q;

   // FIFO bookkeeping; pointers wrap naturally because DEPTH is a power of two.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      mem_d    = mem_q;
      if (push) begin
         mem_d[wr_ptr_q] = {cmd_slot, cmd_x1, cmd_y1, cmd_x2, cmd_y2, cmd_color};
         wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + (PW+1)'(1);
         2'b01:   count_d = count_q - (PW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      lat_cnt_d = lat_cnt_q;
      retries_d = retries_q;
      pAddr     = IDLE_ADDR;
      pDout     = 8'd0;
      we        = 1'b0;
      pop       = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (count_q != '0) begin
               state_d   = S_POLL;
               lat_cnt_d = LAT_INIT;
            end
         end
         S_POLL: begin
            pAddr = A_EOF_COL;
            if (lat_cnt_q != '0)  lat_cnt_d = lat_cnt_q - CW'(1);
            else if (pDin[0])     state_d   = S_W_SLOT;
            else                  lat_cnt_d = LAT_INIT;
         end
         S_W_SLOT: begin
            pAddr = A_SLOT; pDout = {6'b0, head[41:40]}; we = 1'b1; state_d = S_W_X1;
         end
         S_W_X1: begin
            pAddr = A_X1; pDout = head[39:32]; we = 1'b1; state_d = S_W_Y1;
         end
         S_W_Y1: begin
            pAddr = A_Y1; pDout = head[31:24]; we = 1'b1; state_d = S_W_X2;
         end
         S_W_X2: begin
            pAddr = A_X2; pDout = head[23:16]; we = 1'b1; state_d = S_W_Y2;
         end
         S_W_Y2: begin
            pAddr = A_Y2; pDout = head[15:8]; we = 1'b1; state_d = S_W_COL;
         end
         S_W_COL: begin
            pAddr = A_EOF_COL; pDout = head[7:0]; we = 1'b1; state_d = S_HOLD;
         end
         S_HOLD: begin
            state_d   = S_CHECK;
            lat_cnt_d = LAT_INIT;
         end
         S_CHECK: begin
            // Blanking lost mid-update: rewrite the whole slot from the same head entry.
            pAddr = A_EOF_COL;
            if (lat_cnt_q != '0) begin
               lat_cnt_d = lat_cnt_q - CW'(1);
            end else if (pDin[0]) begin
               state_d = S_POP;
            end else begin
               if (retries_q != 8'hFF) retries_d = retries_q + 8'd1;
               state_d   = S_POLL;
               lat_cnt_d = LAT_INIT;
            end
         end
         S_POP: begin
            pop     = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         lat_cnt_q <= '0;
         retries_q <= 8'd0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
      end else begin
         state_q   <= state_d;
         lat_cnt_q <= lat_cnt_d;
         retries_q <= retries_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: tb/tb_vga_rect_loader.sv
// Scoreboard bench for vga_rect_loader: expected register writes are queued as
// commands are issued and a negedge monitor compares every bus write against them.
module tb_vga_rect_loader;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [1:0] cmd_slot = '0;
   logic [7:0] cmd_x1 = '0, cmd_y1 = '0, cmd_x2 = '0, cmd_y2 = '0, cmd_color = '0;
   logic [5:0] pAddr;
   logic [7:0] pDout;
   logic       eof = 1'b0;
   logic [7:0] pDin;
   logic       we, busy;
   logic [2:0] level;
   logic [7:0] retries;

   int n_checks = 0;
   int errors   = 0;
   int wr_seen  = 0;
   logic [13:0] exp_q [$];

   assign pDin = {7'b0, eof};

   vga_rect_loader #(.DEPTH(4), .RD_LAT(2), .IDLE_ADDR(6'd0)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_slot(cmd_slot), .cmd_x1(cmd_x1), .cmd_y1(cmd_y1), .cmd_x2(cmd_x2),
      .cmd_y2(cmd_y2), .cmd_color(cmd_color), .pAddr(pAddr), .pDout(pDout),
      .pDin(pDin), .we(we), .busy(busy), .level(level), .retries(retries)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every write strobe must match the oldest outstanding expected write.
   always @(negedge clk) begin
      if (!rst && we === 1'b1) begin
         wr_seen++;
         n_checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: got %0d:%0h expected none", pAddr, pDout);
         end else begin
            logic [13:0] e;
            e = exp_q.pop_front();
            if ({pAddr, pDout} !== e) begin
               errors++;
               $display("FAIL bus_write: got %0d:%0h expected %0d:%0h",
                        pAddr, pDout, e[13:8], e[7:0]);
            end
         end
      end
   end

   task automatic add_exp(input logic [1:0] s, input logic [7:0] x1, input logic [7:0] y1,
                          input logic [7:0] x2, input logic [7:0] y2, input logic [7:0] c);
      exp_q.push_back({6'd19, 6'b0, s});
      exp_q.push_back({6'd15, x1});
      exp_q.push_back({6'd16, y1});
      exp_q.push_back({6'd17, x2});
      exp_q.push_back({6'd18, y2});
      exp_q.push_back({6'd14, c});
   endtask

   // Called at a negedge; presents the command for exactly one rising edge.
   task automatic push_cmd(input logic [1:0] s, input logic [7:0] x1, input logic [7:0] y1,
                           input logic [7:0] x2, input logic [7:0] y2, input logic [7:0] c,
                           input logic acc);
      cmd_valid = 1'b1; cmd_slot = s; cmd_x1 = x1; cmd_y1 = y1;
      cmd_x2 = x2; cmd_y2 = y2; cmd_color = c;
      check("cmd_ready_at_push", cmd_ready, acc);
      if (acc) add_exp(s, x1, y1, x2, y2, c);
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_write(input logic [5:0] a, input int bound);
      int n = 0;
      while (!(we === 1'b1 && pAddr == a) && n < bound) begin
         @(negedge clk);
         n++;
      end
      if (!(we === 1'b1 && pAddr == a)) begin
         n_checks++; errors++;
         $display("FAIL wait_write: got timeout after %0d cycles expected write to %0d", n, a);
      end
   endtask

   task automatic wait_idle(input int bound);
      int n = 0;
      while (!(busy === 1'b0 && level == 3'd0) && n < bound) begin
         @(negedge clk);
         n++;
      end
      if (!(busy === 1'b0 && level == 3'd0)) begin
         n_checks++; errors++;
         $display("FAIL wait_idle: got busy=%0b level=%0d expected idle and empty", busy, level);
      end
   endtask

   initial begin
      int n, w0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("rst_paddr", pAddr, 6'd0);
      check("rst_we", we, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_level", level, 3'd0);
      check("rst_retries", retries, 8'd0);
      check("rst_ready", cmd_ready, 1'b1);

      // Single command with blanking active: 2*RD_LAT+8 = 12 busy cycles.
      eof = 1'b1;
      push_cmd(2'd2, 8'd10, 8'd20, 8'd40, 8'd60, 8'hE0, 1'b1);
      check("t1_level_after_push", level, 3'd1);
      n = 0;
      while (!busy && n < 10) begin @(negedge clk); n++; end
      n = 0;
      while (busy && n < 100) begin @(negedge clk); n++; end
      check("t1_busy_cycles", n, 12);
      check("t1_level_after", level, 3'd0);
      check("t1_writes", wr_seen, 6);

      // Stall in POLL with blanking inactive, then start within RD_LAT+1 cycles.
      eof = 1'b0;
      push_cmd(2'd1, 8'd3, 8'd4, 8'd5, 8'd6, 8'h1C, 1'b1);
      w0 = wr_seen;
      repeat (50) @(negedge clk);
      check("t2_no_writes", wr_seen, w0);
      check("t2_poll_addr", pAddr, 6'd14);
      check("t2_poll_we", we, 1'b0);
      check("t2_busy", busy, 1'b1);
      eof = 1'b1;
      n = 0;
      while (we !== 1'b1 && n < 10) begin @(negedge clk); n++; end
      check("t2_start_latency_ok", (n >= 1 && n <= 3), 1'b1);
      wait_idle(100);
      check("t2_level", level, 3'd0);

      // Blanking drops during W_X2: retry the whole sequence with identical data.
      push_cmd(2'd3, 8'd50, 8'd51, 8'd2, 8'd1, 8'h0F, 1'b1);
      add_exp(2'd3, 8'd50, 8'd51, 8'd2, 8'd1, 8'h0F);
      w0 = wr_seen;
      wait_write(6'd17, 30);
      eof = 1'b0;
      repeat (10) @(negedge clk);
      check("t3_retries", retries, 8'd1);
      check("t3_level_no_pop", level, 3'd1);
      check("t3_writes_first_pass", wr_seen - w0, 6);
      eof = 1'b1;
      wait_idle(100);
      check("t3_retries_after", retries, 8'd1);
      check("t3_queue_empty", exp_q.size(), 0);

      // FIFO full with blanking inactive, then drain in push order.
      eof = 1'b0;
      push_cmd(2'd0, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 1'b1);
      push_cmd(2'd1, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 1'b1);
      push_cmd(2'd2, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 1'b1);
      push_cmd(2'd3, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 1'b1);
      push_cmd(2'd0, 8'h51, 8'h52, 8'h53, 8'h54, 8'h55, 1'b0);
      check("t4_level_full", level, 3'd4);
      check("t4_ready_full", cmd_ready, 1'b0);
      eof = 1'b1;
      wait_idle(300);
      check("t4_ready_after", cmd_ready, 1'b1);
      check("t4_queue_empty", exp_q.size(), 0);

      // Reset during W_Y1 with three commands queued.
      push_cmd(2'd1, 8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 1'b1);
      push_cmd(2'd2, 8'h71, 8'h72, 8'h73, 8'h74, 8'h75, 1'b1);
      push_cmd(2'd3, 8'h81, 8'h82, 8'h83, 8'h84, 8'h85, 1'b1);
      wait_write(6'd16, 30);
      check("t5_level_before", level, 3'd3);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      exp_q.delete();
      check("t5_paddr", pAddr, 6'd0);
      check("t5_we", we, 1'b0);
      check("t5_busy", busy, 1'b0);
      check("t5_level", level, 3'd0);
      check("t5_retries", retries, 8'd0);
      check("t5_ready", cmd_ready, 1'b1);
      rst = 1'b0;

      // 300 failed CHECKs: retries saturates at 255.
      eof = 1'b1;
      push_cmd(2'd0, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'hAA, 1'b1);
      for (int i = 0; i < 300; i++) begin
         if (i > 0) add_exp(2'd0, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'hAA);
         wait_write(6'd14, 40);
         eof = 1'b0;
         repeat (4) @(negedge clk);
         eof = 1'b1;
         if (i == 9) check("t6_retries_10", retries, 8'd10);
      end
      check("t6_retries_sat", retries, 8'd255);
      add_exp(2'd0, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'hAA);
      wait_idle(100);
      check("t6_level", level, 3'd0);
      check("t6_queue_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, errors);
      $finish;
   end
endmodule
